// File: rtl/game_dumper_pkg.sv
// rtl/game_dumper_pkg.sv - shared states, iNES constants and flag-word layout for the game dumper
package game_dumper_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HEADER  = 3'd1;
    localparam logic [2:0] ST_PRG_REQ = 3'd2;
    localparam logic [2:0] ST_PRG_OUT = 3'd3;
    localparam logic [2:0] ST_CHR_REQ = 3'd4;
    localparam logic [2:0] ST_CHR_OUT = 3'd5;
    localparam logic [2:0] ST_FINISH  = 3'd6;

    localparam logic [7:0] INES_MAGIC_0 = 8'h4E;
    localparam logic [7:0] INES_MAGIC_1 = 8'h45;
    localparam logic [7:0] INES_MAGIC_2 = 8'h53;
    localparam logic [7:0] INES_MAGIC_3 = 8'h1A;

    localparam int FLAG_MAPPER_LSB   = 0;
    localparam int FLAG_PRG_SIZE_LSB = 8;
    localparam int FLAG_CHR_SIZE_LSB = 11;
    localparam int FLAG_MIRRORING    = 14;
    localparam int FLAG_HAS_CHR_RAM  = 15;
    localparam int FLAG_FOUR_SCREEN  = 16;
    localparam int FLAG_USED_W       = 17;

    localparam int PRG_PAGE_SHIFT = 14;
    localparam int CHR_PAGE_SHIFT = 13;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
`ifdef GAME_DUMPER_CRC_EN
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
`endif

    function automatic logic [7:0] header_byte(
        input logic [3:0] idx,
        input logic [7:0] prg_pages,
        input logic [7:0] chr_pages,
        input logic [7:0] mapper,
        input logic       four_screen,
        input logic       mirroring
    );
        case (idx)
            4'd0:    header_byte = INES_MAGIC_0;
            4'd1:    header_byte = INES_MAGIC_1;
            4'd2:    header_byte = INES_MAGIC_2;
            4'd3:    header_byte = INES_MAGIC_3;
            4'd4:    header_byte = prg_pages;
            4'd5:    header_byte = chr_pages;
            4'd6:    header_byte = {mapper[3:0], four_screen, 2'b00, mirroring};
            4'd7:    header_byte = {mapper[7:4], 4'h0};
            default: header_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/crc32_byte.sv
// rtl/crc32_byte.sv - combinational reflected CRC-32 step over one byte (used under GAME_DUMPER_CRC_EN)
module crc32_byte
    import game_dumper_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY_REFL) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/game_dumper.sv
// rtl/game_dumper.sv - streams cartridge memory out as an iNES image; GAME_DUMPER_CRC_EN adds a stream CRC-32
module game_dumper
    import game_dumper_pkg::*;
#(
    parameter int                ADDR_W   = 22,
    parameter logic [ADDR_W-1:0] CHR_BASE = 22'h200000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       mapper_flags,
    input  logic              invert_mirroring,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_valid,
    input  logic [7:0]        mem_din,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [31:0]       crc
);

    logic [2:0]             state;
    logic [3:0]             hdr_idx;
    logic [ADDR_W-1:0]      count;
    logic [FLAG_USED_W-1:0] flags_q;
    logic                   inv_q;
    logic [7:0]             prg_pages;
    logic [7:0]             chr_pages;
    logic [ADDR_W-1:0]      prg_bytes;
    logic [ADDR_W-1:0]      chr_bytes;
    logic                   accept;
    logic                   unused_flags;

    assign prg_pages    = 8'd1 << flags_q[FLAG_PRG_SIZE_LSB +: 3];
    assign chr_pages    = flags_q[FLAG_HAS_CHR_RAM] ? 8'd0 : (8'd1 << flags_q[FLAG_CHR_SIZE_LSB +: 3]);
    assign prg_bytes    = ADDR_W'(prg_pages) << PRG_PAGE_SHIFT;
    assign chr_bytes    = ADDR_W'(chr_pages) << CHR_PAGE_SHIFT;
    assign accept       = out_valid & out_ready;
    assign mem_rd       = (state == ST_PRG_REQ) || (state == ST_CHR_REQ);
    assign unused_flags = ^mapper_flags[31:FLAG_USED_W];

    // out_data doubles as the single-byte buffer: a read is only issued once it has drained
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            hdr_idx   <= 4'd0;
            count     <= '0;
            flags_q   <= '0;
            inv_q     <= 1'b0;
            mem_addr  <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        flags_q   <= mapper_flags[FLAG_USED_W-1:0];
                        inv_q     <= invert_mirroring;
                        busy      <= 1'b1;
                        hdr_idx   <= 4'd0;
                        out_data  <= INES_MAGIC_0;
                        out_valid <= 1'b1;
                        state     <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (accept) begin
                        if (hdr_idx == 4'd15) begin
                            out_valid <= 1'b0;
                            mem_addr  <= '0;
                            count     <= prg_bytes;
                            state     <= ST_PRG_REQ;
                        end else begin
                            hdr_idx  <= hdr_idx + 4'd1;
                            out_data <= header_byte(hdr_idx + 4'd1, prg_pages, chr_pages,
                                                    flags_q[FLAG_MAPPER_LSB +: 8],
                                                    flags_q[FLAG_FOUR_SCREEN],
                                                    flags_q[FLAG_MIRRORING] ^ inv_q);
                        end
                    end
                end
                ST_PRG_REQ, ST_CHR_REQ: begin
                    if (mem_valid) begin
                        out_data  <= mem_din;
                        out_valid <= 1'b1;
                        state     <= (state == ST_PRG_REQ) ? ST_PRG_OUT : ST_CHR_OUT;
                    end
                end
                ST_PRG_OUT, ST_CHR_OUT: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        count     <= count - ADDR_W'(1);
                        if (count != ADDR_W'(1)) begin
                            state <= (state == ST_PRG_OUT) ? ST_PRG_REQ : ST_CHR_REQ;
                        end else if (state == ST_PRG_OUT && chr_bytes != '0) begin
                            mem_addr <= CHR_BASE;
                            count    <= chr_bytes;
                            state    <= ST_CHR_REQ;
                        end else begin
                            state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef GAME_DUMPER_CRC_EN
    logic [31:0] crc_state;
    logic [31:0] crc_next;

    crc32_byte u_crc (
        .crc_in  (crc_state),
        .data    (out_data),
        .crc_out (crc_next)
    );

    // Held un-inverted so the reset value presents as zero on the port
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_state <= CRC_INIT;
        end else if (state == ST_IDLE && start) begin
            crc_state <= CRC_INIT;
        end else if (accept) begin
            crc_state <= crc_next;
        end
    end

    assign crc = ~crc_state;
`else
    assign crc = 32'd0;
`endif

endmodule

// File: doc/game_dumper.md
Name: game_dumper

Overview:
- Streams a loaded game back out of cartridge memory as a well-formed iNES image: a reconstructed 16-byte header, then PRG, then CHR.
- It is the read-side counterpart of the game loader, which parses iNES and writes to memory.
- Sits in emu beside the loader, on the same SDRAM port (CPU-side read path, muxed while dumping), with its byte stream feeding the HPS upload path.

Parameters:
- CHR_BASE, 22'h200000, byte address where CHR data starts in cartridge memory.
- ADDR_W, 22, cartridge memory address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a dump when idle.
- mapper_flags  in  32  loader flag word: [7:0] mapper, [10:8] prg_size, [13:11] chr_size, [14] mirroring, [15] has_chr_ram, [16] four_screen.
- invert_mirroring  in  1  OSD invert; XORed back into header mirroring bit.
- mem_addr  out  22  read address.
- mem_rd  out  1  read request; held until mem_valid.
- mem_valid  in  1  one-cycle pulse, read data valid.
- mem_din  in  8  read data.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse after last byte accepted.
- crc  out  32  CRC-32 of stream (see Optional Feature).

Behaviour:
- Reset values: mem_addr 0, mem_rd 0, out_data 0, out_valid 0, busy 0, done 0, crc 0; state IDLE.
- Decoded lengths: prg_pages = 1<<prg_size (8-bit); chr_pages = has_chr_ram ? 0 : 1<<chr_size. PRG bytes = prg_pages*16384; CHR bytes = chr_pages*8192. Byte counter is 22 bits; max PRG 2 MB fits exactly.
- mapper_flags and invert_mirroring are latched on start and ignored afterwards.
- Header bytes, in order:
  - 4E 45 53 1A
  - prg_pages
  - chr_pages
  - {mapper[3:0], four_screen, 1'b0, 1'b0, mirroring^invert_mirroring}
  - {mapper[7:4], 4'b0}
  - eight 00 bytes
- States:
  - IDLE: start -> HEADER, busy=1, index=0. start while busy is ignored.
  - HEADER: present header[index]; on accept index++; after byte 15 -> PRG_REQ, addr=0, count=PRG bytes.
  - PRG_REQ: assert mem_rd at mem_addr until mem_valid; capture mem_din into out_data, out_valid=1 -> PRG_OUT.
  - PRG_OUT: on accept, addr++, count--; count==0 -> CHR_REQ (addr=CHR_BASE, count=CHR bytes) or FINISH if CHR bytes==0; else -> PRG_REQ.
  - CHR_REQ/CHR_OUT: same as PRG; count==0 -> FINISH.
  - FINISH: done=1 for one cycle, busy=0 -> IDLE.
- Only one read is outstanding at a time. No mem_rd is issued while out_valid=1 (one-byte buffer; backpressure stalls memory).
- out_data is stable while out_valid & !out_ready.
- Minimum throughput: 1 byte per (memory latency + 2) cycles. Header bytes can be accepted every cycle.
- out_valid is registered: asserted the cycle after mem_valid, or the cycle after entering/advancing HEADER.
- Reset mid-operation: immediate return to IDLE with reset values. A mem_valid arriving afterwards while in IDLE is ignored.
- mem_valid when mem_rd=0: ignored.

Optional Feature:
- Macro: GAME_DUMPER_CRC_EN.
- Defined: crc holds a running CRC-32 (poly 04C11DB7 reflected, init FFFFFFFF, final XOR FFFFFFFF) over every accepted byte, header included. It resets to the init value on start and is valid from the done pulse until the next start.
- Undefined: crc is tied to 0 and no CRC logic is built.

Decomposition:
- Package game_dumper_pkg:
  - state enum (IDLE, HEADER, PRG_REQ, PRG_OUT, CHR_REQ, CHR_OUT, FINISH)
  - iNES magic constants
  - mapper_flags bit-position localparams
  - PRG/CHR page-size constants
  - CRC polynomial and init constants
- Sub-module: crc32_byte. Combinational next-CRC from current CRC plus one byte; instantiated only under GAME_DUMPER_CRC_EN.

Test Plan:
- Full dump, CHR ROM: mapper_flags mapper=4, prg_size=3, chr_size=4, mirroring=1, chr_ram=0; out_ready=1; memory model returns addr[7:0] -> header 4E 45 53 1A 08 10 41 00 00x8. Then 131072 PRG bytes from addr 0 (byte n = n[7:0]), then 131072 CHR bytes from 0x200000. Exactly one done pulse; total 262160 bytes.
- CHR RAM: has_chr_ram=1, prg_size=0 -> byte5=00, 16384 PRG bytes, no mem_rd with addr>=0x200000, done after 16400 bytes.
- Backpressure: drop out_ready for 10 cycles mid-PRG -> out_data unchanged, mem_rd stays 0, no byte lost or duplicated.
- Variable latency: mem_valid delayed randomly 1..8 cycles -> stream content identical to the zero-wait run.
- Reset mid-PRG at byte 500 -> next cycle busy=0, out_valid=0. A stray mem_valid is ignored; a new start restarts from header byte 0x4E.
- CRC (macro on): mapper=0, prg_size=0, chr_size=0, zero-filled memory -> crc equals software CRC-32 of the 24592-byte image at done. Macro off: crc==0 throughout.
